// File: rtl/idli_sqi_mem_m.sv
// Nibble-serial SQI memory responder: decodes READ (0x03) / WRITE (0x02) and serves an internal byte array.
// Optional RDMR command (0x05) returning mode byte 0x40 is enabled by defining IDLI_SQI_MEM_RDMR_EN.
module idli_sqi_mem_m #(
    parameter int ADDR_W    = 16,
    parameter int MEM_AW    = 10,
    parameter int DUMMY_CYC = 2
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD,
        WR,
        ERR,
        MODE
    } state_e;

    localparam logic [7:0] LAST_ADDR  = 8'(ADDR_W / 4 - 1);
    localparam logic [7:0] LAST_DUMMY = 8'(DUMMY_CYC - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [3:0]          hiNib_q, hiNib_d;
    logic                isWr_q, isWr_d;
    logic                phase_q, phase_d;
    logic [3:0]          sio_q, sio_d;
    logic                oe_q, oe_d;

    logic [7:0]          mem_q [2**MEM_AW];
    logic [MEM_AW-1:0]   memIdx;
    logic [7:0]          memRdata;
    logic                memWe;

    // Upper address bits are dropped here, which makes the array alias.
    assign memIdx   = addr_q[MEM_AW-1:0];
    assign memRdata = mem_q[memIdx];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hiNib_d = hiNib_q;
        isWr_d  = isWr_q;
        phase_d = phase_q;
        sio_d   = sio_q;
        oe_d    = oe_q;
        memWe   = 1'b0;

        if (i_mem_cs) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            sio_d   = 4'h0;
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    hiNib_d = i_mem_sio;
                    state_d = CMD;
                end
                CMD: begin
                    cnt_d = 8'd0;
                    case ({hiNib_q, i_mem_sio})
                        8'h03: begin
                            isWr_d  = 1'b0;
                            state_d = ADDR;
                        end
                        8'h02: begin
                            isWr_d  = 1'b1;
                            state_d = ADDR;
                        end
`ifdef IDLI_SQI_MEM_RDMR_EN
                        8'h05: begin
                            phase_d = 1'b0;
                            state_d = MODE;
                        end
`endif
                        default: state_d = ERR;
                    endcase
                end
                ADDR: begin
                    addr_d = {addr_q[ADDR_W-5:0], i_mem_sio};
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = 8'd0;
                        phase_d = 1'b0;
                        state_d = isWr_q ? WR : DUMMY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DUMMY: begin
                    if (cnt_q == LAST_DUMMY) begin
                        sio_d   = memRdata[7:4];
                        oe_d    = 1'b1;
                        phase_d = 1'b0;
                        state_d = RD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                // phase_q low: high nibble is on the bus, so the low nibble goes next.
                RD: begin
                    if (!phase_q) begin
                        sio_d   = memRdata[3:0];
                        addr_d  = addr_q + ADDR_W'(1);
                        phase_d = 1'b1;
                    end else begin
                        sio_d   = memRdata[7:4];
                        phase_d = 1'b0;
                    end
                end
                WR: begin
                    if (!phase_q) begin
                        hiNib_d = i_mem_sio;
                        phase_d = 1'b1;
                    end else begin
                        memWe   = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                        phase_d = 1'b0;
                    end
                end
                ERR: begin
                    oe_d  = 1'b0;
                    sio_d = 4'h0;
                end
                MODE: begin
                    oe_d    = 1'b1;
                    sio_d   = phase_q ? 4'h0 : 4'h4;
                    phase_d = ~phase_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            hiNib_q <= 4'h0;
            isWr_q  <= 1'b0;
            phase_q <= 1'b0;
            sio_q   <= 4'h0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hiNib_q <= hiNib_d;
            isWr_q  <= isWr_d;
            phase_q <= phase_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge i_mem_gck) begin
        if (memWe) begin
            mem_q[memIdx] <= {hiNib_q, i_mem_sio};
        end
    end

    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Scoreboard bench for idli_sqi_mem_m: driver pushes expected read nibbles from a byte-array model,
// a negedge monitor pops and compares whenever the responder drives sio.
module tb_idli_sqi_mem_m;

    localparam int ADDR_W     = 16;
    localparam int MEM_AW     = 10;
    localparam int DUMMY_CYC  = 2;
    localparam int MEM_DEPTH  = 2**MEM_AW;

    logic       clk;
    logic       rstN;
    logic       cs;
    logic [3:0] sioIn;
    logic [3:0] sioOut;
    logic       sioOe;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] expQ[$];
    logic [7:0] wrData[$];
    logic [7:0] memModel [MEM_DEPTH];
    logic [3:0] monExp;

    idli_sqi_mem_m #(
        .ADDR_W    (ADDR_W),
        .MEM_AW    (MEM_AW),
        .DUMMY_CYC (DUMMY_CYC)
    ) dut (
        .i_mem_gck    (clk),
        .i_mem_rst_n  (rstN),
        .i_mem_cs     (cs),
        .i_mem_sio    (sioIn),
        .o_mem_sio    (sioOut),
        .o_mem_sio_oe (sioOe)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Drive one edge's worth of inputs, wait for that edge, return 1 time unit after it.
    task automatic applyStimulus(input logic c, input logic [3:0] n);
        cs    = c;
        sioIn = n;
        @(posedge clk);
        #1;
    endtask

    // The monitor owns the read-data comparisons; any drive with nothing expected is an error.
    always @(negedge clk) begin
        if (sioOe === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_oe: got oe=1 sio=%0h required oe=0", sioOut);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rd_nibble", int'(sioOut), int'(monExp));
            end
        end
    end

    task automatic doWrite(input logic [15:0] a, input bit extra, input logic [3:0] extraNib);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h2);
        for (int k = 3; k >= 0; k--) applyStimulus(1'b0, a[k*4 +: 4]);
        for (int j = 0; j < wrData.size(); j++) begin
            applyStimulus(1'b0, wrData[j][7:4]);
            applyStimulus(1'b0, wrData[j][3:0]);
            memModel[(int'(a) + j) % MEM_DEPTH] = wrData[j];
        end
        if (extra) applyStimulus(1'b0, extraNib);
        applyStimulus(1'b1, 4'h0);
        checkOutput("wr_oe", int'(sioOe), 0);
        wrData.delete();
    endtask

    task automatic doRead(input logic [15:0] a, input int n, input bit rstAbort);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = memModel[(int'(a) + i / 2) % MEM_DEPTH];
            expQ.push_back((i % 2 == 0) ? b[7:4] : b[3:0]);
        end
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h3);
        for (int k = 3; k >= 0; k--) applyStimulus(1'b0, a[k*4 +: 4]);
        for (int d = 0; d < DUMMY_CYC; d++) applyStimulus(1'b0, 4'($urandom));
        for (int i = 1; i < n; i++) applyStimulus(1'b0, 4'($urandom));
        if (rstAbort) begin
            #5;
            rstN = 1'b0;
            #1;
            checkOutput("rst_async_oe", int'(sioOe), 0);
            checkOutput("rst_async_sio", int'(sioOut), 0);
            cs = 1'b1;
            @(posedge clk);
            #1;
            rstN = 1'b1;
        end
        applyStimulus(1'b1, 4'h0);
        checkOutput("abort_oe", int'(sioOe), 0);
        checkOutput("rd_drain", expQ.size(), 0);
    endtask

    initial begin
        rstN  = 1'b0;
        cs    = 1'b1;
        sioIn = 4'h0;
        #3;
        checkOutput("reset_oe", int'(sioOe), 0);
        checkOutput("reset_sio", int'(sioOut), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(1'b1, 4'h0);

        // Fill the whole array so every later read has a known expectation.
        for (int i = 0; i < MEM_DEPTH; i++) wrData.push_back(8'($urandom));
        doWrite(16'h0000, 1'b0, 4'h0);

        wrData.push_back(8'hA5);
        wrData.push_back(8'h3C);
        doWrite(16'h0010, 1'b0, 4'h0);
        doRead(16'h0010, 4, 1'b0);

        wrData.push_back(8'h11);
        wrData.push_back(8'h22);
        doWrite(16'h03FF, 1'b0, 4'h0);
        doRead(16'h0000, 2, 1'b0);
        doRead(16'h0400, 2, 1'b0);
        doRead(16'h03FF, 4, 1'b0);

        doWrite(16'h0020, 1'b1, 4'hF);
        doRead(16'h0020, 2, 1'b0);
        doRead(16'h0010, 3, 1'b0);

        // Unknown command whose trailing nibbles would look like a write to 0x0010.
        applyStimulus(1'b0, 4'h9);
        applyStimulus(1'b0, 4'hB);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("err_oe", int'(sioOe), 0);
        applyStimulus(1'b0, 4'h1);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'hF);
        applyStimulus(1'b0, 4'hF);
        applyStimulus(1'b0, 4'hE);
        applyStimulus(1'b0, 4'hE);
        applyStimulus(1'b1, 4'h0);
        doRead(16'h0010, 4, 1'b0);

        doRead(16'h0010, 3, 1'b1);
        doRead(16'h0010, 4, 1'b0);

`ifdef IDLI_SQI_MEM_RDMR_EN
        expQ.push_back(4'h4);
        expQ.push_back(4'h0);
        expQ.push_back(4'h4);
        expQ.push_back(4'h0);
`endif
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h5);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
`ifdef IDLI_SQI_MEM_RDMR_EN
        checkOutput("rdmr_oe", int'(sioOe), 1);
`else
        checkOutput("rdmr_oe", int'(sioOe), 0);
`endif
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b1, 4'h0);
        checkOutput("rdmr_drain", expQ.size(), 0);

        // Randomised mix of streaming writes (some with a dangling nibble) and reads.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 5)); j++) wrData.push_back(8'($urandom));
                doWrite(16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
            end else begin
                doRead(16'($urandom), int'($urandom_range(1, 9)), 1'b0);
            end
        end

        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h0);
        checkOutput("final_drain", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
